// File: rtl/mul255_check_if.sv
// mul255_check handshake and data bundle.
// Upstream drives start/q/x_ref/ack; the checker returns status and product.
interface mul255_check_if;
    logic        start;
    logic [31:0] q;
    logic [31:0] x_ref;
    logic        ack;
    logic        busy;
    logic        done;
    logic [39:0] p;
    logic        exact;

    modport master (
        output start, q, x_ref, ack,
        input  busy, done, p, exact
    );

    modport slave (
        input  start, q, x_ref, ack,
        output busy, done, p, exact
    );
endinterface

// File: rtl/mul255_check.sv
// Byte-serial q*255 = (q<<8)-q checker with start/ack handshake.
// Optional MUL255_ERRCNT_EN adds a saturating err_cnt of inexact results.
module mul255_check (
    input  logic          clk,
    input  logic          rst_n,
    mul255_check_if.slave bus
`ifdef MUL255_ERRCNT_EN
    ,
    output logic [15:0]   err_cnt
`endif
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_B0   = 4'd1;
    localparam logic [3:0] S_B1   = 4'd2;
    localparam logic [3:0] S_B2   = 4'd3;
    localparam logic [3:0] S_B3   = 4'd4;
    localparam logic [3:0] S_B4   = 4'd5;
    localparam logic [3:0] S_CMP  = 4'd6;
    localparam logic [3:0] S_DONE = 4'd7;

    logic [3:0]  state_q, state_d;
    logic [31:0] q_q, q_d;
    logic [31:0] xr_q, xr_d;
    logic [39:0] pint_q, pint_d;
    logic        borrow_q, borrow_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [39:0] p_q, p_d;
    logic        exact_q, exact_d;
    logic        cmp_exact;

    logic [39:0] min_w;
    logic [39:0] sub_w;
    logic [2:0]  idx;
    logic [7:0]  min_b;
    logic [7:0]  sub_b;
    logic [8:0]  diff_w;

    // Minuend is Q shifted up a byte, subtrahend is Q itself.
    assign min_w = {q_q, 8'h00};
    assign sub_w = {8'h00, q_q};

    // Byte index of the current subtract step.
    always_comb begin
        idx = 3'd0;
        case (state_q)
            S_B1:    idx = 3'd1;
            S_B2:    idx = 3'd2;
            S_B3:    idx = 3'd3;
            S_B4:    idx = 3'd4;
            default: idx = 3'd0;
        endcase
    end

    assign min_b  = min_w[{idx, 3'b000} +: 8];
    assign sub_b  = sub_w[{idx, 3'b000} +: 8];
    assign diff_w = {1'b0, min_b} - {1'b0, sub_b}
                  - {8'h00, borrow_q};

    assign cmp_exact = (pint_q[39:32] == 8'h00)
                    && (pint_q[31:0] == xr_q);

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        xr_d     = xr_q;
        pint_d   = pint_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = done_q;
        p_d      = p_q;
        exact_d  = exact_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    q_d      = bus.q;
                    xr_d     = bus.x_ref;
                    borrow_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_B0;
                end
            end
            S_B0, S_B1, S_B2, S_B3, S_B4: begin
                pint_d[{idx, 3'b000} +: 8] = diff_w[7:0];
                borrow_d = diff_w[8];
                state_d  = (state_q == S_B4) ? S_CMP
                                             : state_q + 4'd1;
            end
            S_CMP: begin
                p_d     = pint_q;
                exact_d = cmp_exact;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.ack) begin
                    done_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            xr_q     <= '0;
            pint_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            p_q      <= '0;
            exact_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            xr_q     <= xr_d;
            pint_q   <= pint_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            p_q      <= p_d;
            exact_q  <= exact_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.p     = p_q;
    assign bus.exact = exact_q;

`ifdef MUL255_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count inexact results on the compare edge, saturating.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == S_CMP && !cmp_exact
            && err_cnt_q != 16'hFFFF)
            err_cnt_d = err_cnt_q + 16'd1;
    end

    // Error counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule
